// File: rtl/z80fi_pkg.sv
// Shared definitions for the z80fi instruction collector.
// Holds the collector state encoding and the default MAX_LEN.
package z80fi_pkg;

    localparam int Z80FI_MAX_LEN = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2
    } z80fi_state_e;

endpackage

// File: rtl/z80fi_byte_packer.sv
// Next-value logic for the collect buffer: clears on a new instruction,
// appends bytes by lane, and flags bytes that no longer fit.
// Ports: buf_i/cnt_i/ovf_i current buffer state; start_i (new insn),
//        append_i (next byte), data_i byte; buf_o/cnt_o/ovf_o next state.
module z80fi_byte_packer #(
    parameter int MAX_LEN = 4,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [8*MAX_LEN-1:0] buf_i,
    input  logic [LEN_W-1:0]     cnt_i,
    input  logic                 ovf_i,
    input  logic                 start_i,
    input  logic                 append_i,
    input  logic [7:0]           data_i,
    output logic [8*MAX_LEN-1:0] buf_o,
    output logic [LEN_W-1:0]     cnt_o,
    output logic                 ovf_o
);

    always_comb begin
        buf_o = buf_i;
        cnt_o = cnt_i;
        ovf_o = ovf_i;
        if (start_i) begin
            buf_o      = '0;
            buf_o[7:0] = data_i;
            cnt_o      = LEN_W'(1);
            ovf_o      = 1'b0;
        end else if (append_i) begin
            if (cnt_i == LEN_W'(MAX_LEN)) begin
                // Full: drop the byte, remember it for this insn.
                ovf_o = 1'b1;
            end else begin
                for (int k = 0; k < MAX_LEN; k++) begin
                    if (cnt_i == LEN_W'(k)) begin
                        buf_o[8*k +: 8] = data_i;
                    end
                end
                cnt_o = cnt_i + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/z80fi_insn_collector.sv
// Gathers the bytes of one Z80 instruction and presents them with its PC.
// In: clk, reset_n, fetch_valid/first/data/pc, insn_done.
// Out: z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_pc_rdata,
//      overflow, aborted.
module z80fi_insn_collector
    import z80fi_pkg::*;
#(
    parameter int MAX_LEN = Z80FI_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 fetch_valid,
    input  logic                 fetch_first,
    input  logic [7:0]           fetch_data,
    input  logic [15:0]          fetch_pc,
    input  logic                 insn_done,
    output logic                 z80fi_valid,
    output logic [8*MAX_LEN-1:0] z80fi_insn,
    output logic [LEN_W-1:0]     z80fi_insn_len,
    output logic [15:0]          z80fi_pc_rdata,
    output logic                 overflow,
    output logic                 aborted
);

    z80fi_state_e state_q, state_d;

    logic [8*MAX_LEN-1:0] buf_q, buf_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [15:0]          pc_q;

    logic [8*MAX_LEN-1:0] out_insn_q;
    logic [LEN_W-1:0]     out_len_q;
    logic [15:0]          out_pc_q;
    logic                 out_ovf_q;
    logic                 valid_q;
    logic                 aborted_q;

    logic start, append, capture, abort;

    assign start  = fetch_valid & fetch_first;
    assign append = fetch_valid & ~fetch_first & (state_q == COLLECT);

    z80fi_byte_packer #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_packer (
        .buf_i    (buf_q),
        .cnt_i    (cnt_q),
        .ovf_i    (ovf_q),
        .start_i  (start),
        .append_i (append),
        .data_i   (fetch_data),
        .buf_o    (buf_d),
        .cnt_o    (cnt_d),
        .ovf_o    (ovf_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = COLLECT;
            end
            COLLECT: begin
                if (start)          state_d = COLLECT;
                else if (insn_done) state_d = PRESENT;
            end
            PRESENT: begin
                state_d = start ? COLLECT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        capture = (state_q == COLLECT) & insn_done;
        abort   = (state_q == COLLECT) & start & ~insn_done;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            pc_q  <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (start) pc_q <= fetch_pc;
        end
    end

    // A first byte in the done cycle belongs to the next insn, so the
    // old buffer is presented; otherwise the same-cycle byte is included.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_insn_q <= '0;
            out_len_q  <= '0;
            out_pc_q   <= '0;
            out_ovf_q  <= 1'b0;
            valid_q    <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            valid_q   <= capture;
            aborted_q <= abort;
            if (capture) begin
                out_insn_q <= start ? buf_q : buf_d;
                out_len_q  <= start ? cnt_q : cnt_d;
                out_ovf_q  <= start ? ovf_q : ovf_d;
                out_pc_q   <= pc_q;
            end
        end
    end

    assign z80fi_valid    = valid_q;
    assign z80fi_insn     = out_insn_q;
    assign z80fi_insn_len = out_len_q;
    assign z80fi_pc_rdata = out_pc_q;
    assign overflow       = out_ovf_q;
    assign aborted        = aborted_q;

endmodule

// File: tb/tb_z80fi_insn_collector.sv
// Directed bench for z80fi_insn_collector with MAX_LEN = 4.
// Each step drives one cycle of inputs and checks outputs 1 ns after the edge.
module tb_z80fi_insn_collector;

    localparam int MAX_LEN = 4;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic                 clk;
    logic                 reset_n;
    logic                 fetch_valid;
    logic                 fetch_first;
    logic [7:0]           fetch_data;
    logic [15:0]          fetch_pc;
    logic                 insn_done;
    logic                 z80fi_valid;
    logic [8*MAX_LEN-1:0] z80fi_insn;
    logic [LEN_W-1:0]     z80fi_insn_len;
    logic [15:0]          z80fi_pc_rdata;
    logic                 overflow;
    logic                 aborted;

    int checks = 0;
    int errors = 0;

    z80fi_insn_collector #(
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_valid    (fetch_valid),
        .fetch_first    (fetch_first),
        .fetch_data     (fetch_data),
        .fetch_pc       (fetch_pc),
        .insn_done      (insn_done),
        .z80fi_valid    (z80fi_valid),
        .z80fi_insn     (z80fi_insn),
        .z80fi_insn_len (z80fi_insn_len),
        .z80fi_pc_rdata (z80fi_pc_rdata),
        .overflow       (overflow),
        .aborted        (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic f, input logic [7:0] d,
                       input logic [15:0] pc, input logic done);
        fetch_valid = v;
        fetch_first = f;
        fetch_data  = d;
        fetch_pc    = pc;
        insn_done   = done;
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        fetch_first = 1'b0;
        fetch_data  = 8'h00;
        fetch_pc    = 16'h0000;
        insn_done   = 1'b0;
    endtask

    task automatic chk_pres(input string tag, input logic [31:0] insn,
                            input int len, input logic [15:0] pc,
                            input logic ovf);
        chk({tag, "_valid"}, 64'(z80fi_valid), 64'd1);
        chk({tag, "_insn"}, 64'(z80fi_insn), 64'(insn));
        chk({tag, "_len"}, 64'(z80fi_insn_len), 64'(len));
        chk({tag, "_pc"}, 64'(z80fi_pc_rdata), 64'(pc));
        chk({tag, "_ovf"}, 64'(overflow), 64'(ovf));
    endtask

    initial begin
        reset_n     = 1'b0;
        fetch_valid = 1'b0;
        fetch_first = 1'b0;
        fetch_data  = 8'h00;
        fetch_pc    = 16'h0000;
        insn_done   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(z80fi_valid), 64'd0);
        chk("rst_insn", 64'(z80fi_insn), 64'd0);
        chk("rst_len", 64'(z80fi_insn_len), 64'd0);
        chk("rst_aborted", 64'(aborted), 64'd0);
        reset_n = 1'b1;

        // done in IDLE produces nothing
        cyc(0, 0, 8'h00, 16'h0000, 1);
        chk("idle_done_valid", 64'(z80fi_valid), 64'd0);

        // 01 34 12 @0100
        cyc(1, 1, 8'h01, 16'h0100, 0);
        cyc(1, 0, 8'h34, 16'h0000, 0);
        cyc(1, 0, 8'h12, 16'h0000, 0);
        chk("t1_pre_valid", 64'(z80fi_valid), 64'd0);
        cyc(0, 0, 8'h00, 16'h0000, 1);
        chk_pres("t1", 32'h0012_3401, 3, 16'h0100, 1'b0);
        cyc(0, 0, 8'h00, 16'h0000, 0);
        chk("t1_pulse_end", 64'(z80fi_valid), 64'd0);
        chk("t1_hold_insn", 64'(z80fi_insn), 64'h0012_3401);
        chk("t1_hold_pc", 64'(z80fi_pc_rdata), 64'h0100);

        // DD 21 CD AB @0200
        cyc(1, 1, 8'hDD, 16'h0200, 0);
        cyc(1, 0, 8'h21, 16'h0000, 0);
        cyc(1, 0, 8'hCD, 16'h0000, 0);
        cyc(1, 0, 8'hAB, 16'h0000, 0);
        cyc(0, 0, 8'h00, 16'h0000, 1);
        chk_pres("t2", 32'hABCD_21DD, 4, 16'h0200, 1'b0);

        // DD DD DD 21 00 @0300: fifth byte overflows
        cyc(1, 1, 8'hDD, 16'h0300, 0);
        cyc(1, 0, 8'hDD, 16'h0000, 0);
        cyc(1, 0, 8'hDD, 16'h0000, 0);
        cyc(1, 0, 8'h21, 16'h0000, 0);
        cyc(1, 0, 8'h00, 16'h0000, 0);
        cyc(0, 0, 8'h00, 16'h0000, 1);
        chk_pres("t3", 32'h21DD_DDDD, 4, 16'h0300, 1'b1);
        cyc(0, 0, 8'h00, 16'h0000, 0);
        chk("t3_hold_ovf", 64'(overflow), 64'd1);

        // 3E then new first 06 without done -> abort
        cyc(1, 1, 8'h3E, 16'h0400, 0);
        chk("t4_no_abort", 64'(aborted), 64'd0);
        cyc(1, 1, 8'h06, 16'h0410, 0);
        chk("t4_abort", 64'(aborted), 64'd1);
        chk("t4_abort_valid", 64'(z80fi_valid), 64'd0);
        // 55 arrives with done and must be included
        cyc(1, 0, 8'h55, 16'h0000, 1);
        chk("t4_abort_end", 64'(aborted), 64'd0);
        chk_pres("t4", 32'h0000_5506, 2, 16'h0410, 1'b0);

        // 00, then first C9 in the done cycle
        cyc(1, 1, 8'h00, 16'h0500, 0);
        cyc(1, 1, 8'hC9, 16'h0501, 1);
        chk_pres("t5a", 32'h0000_0000, 1, 16'h0500, 1'b0);
        chk("t5a_aborted", 64'(aborted), 64'd0);
        cyc(0, 0, 8'h00, 16'h0000, 1);
        chk_pres("t5b", 32'h0000_00C9, 1, 16'h0501, 1'b0);

        // reset in the middle of 01 34
        cyc(1, 1, 8'h01, 16'h0600, 0);
        cyc(1, 0, 8'h34, 16'h0000, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_insn", 64'(z80fi_insn), 64'd0);
        chk("t6_rst_len", 64'(z80fi_insn_len), 64'd0);
        chk("t6_rst_pc", 64'(z80fi_pc_rdata), 64'd0);
        chk("t6_rst_valid", 64'(z80fi_valid), 64'd0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        cyc(0, 0, 8'h00, 16'h0000, 1);
        chk("t6_no_valid", 64'(z80fi_valid), 64'd0);
        chk("t6_no_abort", 64'(aborted), 64'd0);

        // normal collection after reset; stray byte in IDLE ignored
        cyc(1, 0, 8'h99, 16'h0000, 0);
        cyc(1, 1, 8'h77, 16'h0700, 0);
        cyc(1, 0, 8'h88, 16'h0000, 0);
        cyc(0, 0, 8'h00, 16'h0000, 1);
        chk_pres("t7", 32'h0000_8877, 2, 16'h0700, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
